// File: rtl/pc_redirect_unit_pkg.sv
// ============================================================================
// Module  : pc_redirect_unit_pkg
// Brief   : Shared types and defaults for the OTTER PC redirect unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_redirect_unit_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JAL    = 3'd3,
        PC_TRAP   = 3'd4,
        PC_MRET   = 3'd5
    } pcsrc_t;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } redir_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam int          DEFAULT_CNT_W     = 16;

    // Codes 6/7 and an unqualified trap request collapse to sequential flow.
    function automatic pcsrc_t decode_src(input logic [2:0] raw, input logic int_taken);
        pcsrc_t src;
        case (raw)
            3'd1:    src = PC_JALR;
            3'd2:    src = PC_BRANCH;
            3'd3:    src = PC_JAL;
            3'd4:    src = int_taken ? PC_TRAP : PC_SEQ;
            3'd5:    src = PC_MRET;
            default: src = PC_SEQ;
        endcase
        return src;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
// ============================================================================
// Module  : pc_redirect_unit_if
// Brief   : Valid/ready fetch-request bus between PC unit and instruction memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_redirect_unit_if;
    logic [31:0] pc;
    logic        pc_valid;
    logic        fetch_ready;

    modport master (output pc, output pc_valid, input fetch_ready);
    modport slave  (input pc, input pc_valid, output fetch_ready);
endinterface

`default_nettype wire

// File: rtl/pc_redirect_unit_next_mux.sv
// ============================================================================
// Module  : pc_redirect_unit_next_mux
// Brief   : Redirect target select with JALR bit-0 clear and word alignment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit_next_mux
    import pc_redirect_unit_pkg::*;
(
    input  pcsrc_t      src_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] jal_tgt_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    logic [31:0] w_raw;

    always_comb begin
        w_raw = 32'h0;
        case (src_i)
            PC_JALR:   w_raw = jalr_tgt_i & ~32'h1;
            PC_BRANCH: w_raw = branch_tgt_i;
            PC_JAL:    w_raw = jal_tgt_i;
            PC_TRAP:   w_raw = mtvec_i;
            PC_MRET:   w_raw = mepc_i;
            default:   w_raw = 32'h0;
        endcase
    end

    assign redirect_o = (src_i != PC_SEQ);
    // Misalignment is flagged but fetch always proceeds from the word address.
    assign misalign_o = redirect_o && (w_raw[1:0] != 2'b00);
    assign target_o   = {w_raw[31:2], 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
// Module  : pc_redirect_unit
// Brief   : OTTER program counter owner: next-PC select, flushes, mepc write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int          CNT_W     = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_redirect_unit_if.master  fetch_if,
    input  logic                stall_i,
    input  logic [2:0]          pc_source_i,
    input  logic                int_taken_i,
    input  logic [31:0]         ex_pc_i,
    input  logic [31:0]         jalr_tgt_i,
    input  logic [31:0]         branch_tgt_i,
    input  logic [31:0]         jal_tgt_i,
    input  logic [31:0]         mtvec_i,
    input  logic [31:0]         mepc_i,
    output logic                flush_ifid_o,
    output logic                flush_idex_o,
    output logic                mepc_we_o,
    output logic [31:0]         mepc_wdata_o,
    output logic                misalign_o,
    output logic [CNT_W-1:0]    redir_cnt_o
);

    redir_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pend_q, pend_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    pcsrc_t            w_src;
    logic              w_redir_raw;
    logic              w_misalign_raw;
    logic [31:0]       w_target;
    logic              w_redir;
    logic              w_accept;
    logic [31:0]       w_pend_next;

    assign w_src = decode_src(pc_source_i, int_taken_i);

    pc_redirect_unit_next_mux u_next_mux (
        .src_i        (w_src),
        .jalr_tgt_i   (jalr_tgt_i),
        .branch_tgt_i (branch_tgt_i),
        .jal_tgt_i    (jal_tgt_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .redirect_o   (w_redir_raw),
        .target_o     (w_target),
        .misalign_o   (w_misalign_raw)
    );

    assign w_redir     = (state_q != ST_BOOT) && w_redir_raw;
    assign w_accept    = (state_q == ST_WAIT_ACK) && fetch_if.fetch_ready;
    assign w_pend_next = w_redir ? w_target : pend_q;

    // The fetch accepted while waiting was issued for the old path: kill it.
    assign flush_ifid_o = w_redir || w_accept;
    assign flush_idex_o = w_redir;
    assign misalign_o   = w_redir && w_misalign_raw;
    assign mepc_we_o    = w_redir && (w_src == PC_TRAP);
    assign mepc_wdata_o = ex_pc_i + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (w_redir) begin
                    if (fetch_if.fetch_ready || !valid_q) begin
                        pc_d = w_target;
                    end else begin
                        pend_d  = w_target;
                        state_d = ST_WAIT_ACK;
                    end
                end else if (valid_q && fetch_if.fetch_ready && !stall_i) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_WAIT_ACK: begin
                if (fetch_if.fetch_ready) begin
                    pc_d    = w_pend_next;
                    state_d = ST_RUN;
                end else begin
                    pend_d = w_pend_next;
                end
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
        if (w_redir && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fetch_if.pc       = pc_q;
    assign fetch_if.pc_valid = valid_q;
    assign redir_cnt_o       = cnt_q;

endmodule

`default_nettype wire
